// File: rtl/assoc_seq_search_if.sv
// Query and result valid/ready channels of the associative-search engine.
// Optional threshold signals exist only when ASSOC_THRESH_EN is defined.
interface assoc_seq_search_if #(
  parameter int DIM   = 50,
  parameter int IDX_W = 5,
  parameter int CNT_W = 6
);
  // A transfer happens on a rising edge where valid and ready are both high;
  // valid, once raised, holds with its payload stable until that edge.
  logic             q_valid;
  logic             q_ready;
  logic [DIM-1:0]   query_hv;
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_class;
  logic [CNT_W-1:0] res_score;
`ifdef ASSOC_THRESH_EN
  logic [CNT_W-1:0] score_thresh;
  logic             res_hit;
`endif

  modport master (
    output q_valid, query_hv, res_ready,
`ifdef ASSOC_THRESH_EN
    output score_thresh,
    input  res_hit,
`endif
    input  q_ready, res_valid, res_class, res_score
  );

  modport slave (
    input  q_valid, query_hv, res_ready,
`ifdef ASSOC_THRESH_EN
    input  score_thresh,
    output res_hit,
`endif
    output q_ready, res_valid, res_class, res_score
  );
endinterface

// File: rtl/assoc_seq_search.sv
// Sequential associative search: one AND+popcount lane scans the stored class
// hypervectors, one per cycle. Optional score threshold: ASSOC_THRESH_EN.
module assoc_seq_search #(
  parameter int DIM       = 50,
  parameter int NUM_CLASS = 26,
  parameter int IDX_W     = 5,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cls_we,
  input  logic [IDX_W-1:0] cls_waddr,
  input  logic [DIM-1:0]   cls_wdata,
  output logic             busy,
  output logic [1:0]       state_dbg,
  assoc_seq_search_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [DIM-1:0]   r_mem [NUM_CLASS];
  logic [DIM-1:0]   r_query;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_best_idx;
  logic [CNT_W-1:0] r_best_score;
  logic             r_res_valid;
  logic [IDX_W-1:0] r_res_class;
  logic [CNT_W-1:0] r_res_score;
  logic             r_shadow_vld;
  logic [IDX_W-1:0] r_shadow_addr;
  logic [DIM-1:0]   r_shadow_data;

  logic             w_accept;
  logic             w_wr_en;
  logic             w_last;
  logic             w_res_hs;
  logic [DIM-1:0]   w_cls;
  logic [CNT_W-1:0] w_score;

  function automatic logic [CNT_W-1:0] popcount(input logic [DIM-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DIM; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.q_valid;
  assign w_wr_en  = (r_state == S_IDLE) && cls_we && (cls_waddr <= LAST_IDX);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_res_hs = r_res_valid && bus.res_ready;
  // A write coinciding with query acceptance must not leak into that scan,
  // so the overwritten entry is kept aside for the duration of the scan.
  assign w_cls    = (r_shadow_vld && (r_shadow_addr == r_idx)) ? r_shadow_data : r_mem[r_idx];
  assign w_score  = popcount(r_query & w_cls);

  assign bus.q_ready   = (r_state == S_IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_class = r_res_class;
  assign bus.res_score = r_res_score;
  assign busy          = (r_state != S_IDLE);
  assign state_dbg     = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SCAN;
      S_SCAN:  if (w_last)   w_next = S_DONE;
      S_DONE:  if (w_res_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASS; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[cls_waddr] <= cls_wdata;
    end
  end

`ifdef ASSOC_THRESH_EN
  logic [CNT_W-1:0] r_thresh;
  logic             r_res_hit;
  assign bus.res_hit = r_res_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_thresh  <= '0;
      r_res_hit <= 1'b0;
    end else if (w_accept) begin
      r_thresh <= bus.score_thresh;
    end else if (r_state == S_DONE) begin
      if (!r_res_valid)  r_res_hit <= (r_best_score >= r_thresh);
      else if (w_res_hs) r_res_hit <= 1'b0;
    end
  end
`endif

  // DONE spends its first cycle publishing the winner into the result
  // registers, which then hold steady under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_query       <= '0;
      r_idx         <= '0;
      r_best_idx    <= '0;
      r_best_score  <= '0;
      r_res_valid   <= 1'b0;
      r_res_class   <= '0;
      r_res_score   <= '0;
      r_shadow_vld  <= 1'b0;
      r_shadow_addr <= '0;
      r_shadow_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_query       <= bus.query_hv;
            r_idx         <= '0;
            r_best_idx    <= '0;
            r_best_score  <= '0;
            r_shadow_vld  <= w_wr_en;
            r_shadow_addr <= cls_waddr;
            r_shadow_data <= w_wr_en ? r_mem[cls_waddr] : '0;
          end
        end
        S_SCAN: begin
          if (w_score > r_best_score) begin
            r_best_idx   <= r_idx;
            r_best_score <= w_score;
          end
          if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
        S_DONE: begin
          if (!r_res_valid) begin
            r_res_valid <= 1'b1;
            r_res_class <= r_best_idx;
            r_res_score <= r_best_score;
          end else if (w_res_hs) begin
            r_res_valid  <= 1'b0;
            r_shadow_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_assoc_seq_search.sv
// Directed bench for assoc_seq_search: vector table plus hand sequences for
// back-pressure, write lockout, coincident write and reset mid-scan.
module tb_assoc_seq_search;
  localparam int DIM = 50;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;
  localparam logic [DIM-1:0] ALL1 = {DIM{1'b1}};

  logic             clk;
  logic             rst;
  logic             cls_we;
  logic [IDX_W-1:0] cls_waddr;
  logic [DIM-1:0]   cls_wdata;
  logic             busy;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  assoc_seq_search_if #(.DIM(DIM), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  assoc_seq_search #(.DIM(DIM), .NUM_CLASS(26), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cls_we(cls_we), .cls_waddr(cls_waddr),
    .cls_wdata(cls_wdata), .busy(busy), .state_dbg(state_dbg), .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [IDX_W-1:0] a_addr;
    logic [DIM-1:0]   a_data;
    logic [IDX_W-1:0] b_addr;
    logic [DIM-1:0]   b_data;
    logic [DIM-1:0]   q;
    logic [IDX_W-1:0] e_class;
    logic [CNT_W-1:0] e_score;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: called #1 after a rising edge, return #1 after a rising edge
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic write_cls(input logic [IDX_W-1:0] a, input logic [DIM-1:0] d);
    cls_we = 1'b1; cls_waddr = a; cls_wdata = d;
    @(posedge clk); #1;
    cls_we = 1'b0;
  endtask

  task automatic start_query(input string name, input logic [DIM-1:0] q);
    bus.q_valid = 1'b1; bus.query_hv = q;
    check({name, " q_ready"}, 64'(bus.q_ready), 64'd1);
    @(posedge clk); #1;
    bus.q_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_lat,
                             input logic [IDX_W-1:0] e_c, input logic [CNT_W-1:0] e_s);
    int n;
    n = 0;
    while (!bus.res_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " class"}, 64'(bus.res_class), 64'(e_c));
    check({name, " score"}, 64'(bus.res_score), 64'(e_s));
  endtask

  task automatic finish_result(input string name);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check({name, " idle q_ready"}, 64'(bus.q_ready), 64'd1);
    check({name, " idle res_valid"}, 64'(bus.res_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cls_we = 1'b0; cls_waddr = '0; cls_wdata = '0;
    bus.q_valid = 1'b0; bus.query_hv = '0; bus.res_ready = 1'b0;
`ifdef ASSOC_THRESH_EN
    bus.score_thresh = '0;
`endif
    vecs[0] = '{5'd0, 50'b10001, 5'd1, 50'b01110, 50'b11111, 5'd1, 6'd3};
    vecs[1] = '{5'd0, 50'b00011, 5'd1, 50'b00011, 50'b00011, 5'd0, 6'd2};
    vecs[2] = '{5'd0, 50'd0, 5'd1, 50'd0, 50'h2_A5A5_1234_5678, 5'd0, 6'd0};
    vecs[3] = '{5'd25, ALL1, 5'd3, 50'hFF, ALL1, 5'd25, 6'd50};
    vecs[4] = '{5'd7, 50'hF0, 5'd20, 50'hFF0, 50'hFF, 5'd7, 6'd4};
    vecs[5] = '{5'd30, ALL1, 5'd2, 50'h1, ALL1, 5'd2, 6'd1};

    do_reset();
    check("reset q_ready", 64'(bus.q_ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset res_valid", 64'(bus.res_valid), 64'd0);
    check("reset res_class", 64'(bus.res_class), 64'd0);
    check("reset res_score", 64'(bus.res_score), 64'd0);
    check("reset state", 64'(state_dbg), 64'd0);

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      do_reset();
      write_cls(vecs[i].a_addr, vecs[i].a_data);
      write_cls(vecs[i].b_addr, vecs[i].b_data);
      start_query(nm, vecs[i].q);
      check({nm, " busy"}, 64'(busy), 64'd1);
      wait_result(nm, 27, vecs[i].e_class, vecs[i].e_score);
      finish_result(nm);
    end

    // back-pressure, and a pending query held off until after the handshake
    do_reset();
    write_cls(5'd0, 50'b10001);
    write_cls(5'd1, 50'b01110);
    start_query("bp", 50'b11111);
    wait_result("bp", 27, 5'd1, 6'd3);
    bus.q_valid = 1'b1; bus.query_hv = ALL1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp hold valid", 64'(bus.res_valid), 64'd1);
      check("bp hold class", 64'(bus.res_class), 64'd1);
      check("bp hold score", 64'(bus.res_score), 64'd3);
      check("bp hold q_ready", 64'(bus.q_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("bp after hs q_ready", 64'(bus.q_ready), 64'd1);
    check("bp after hs busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    bus.q_valid = 1'b0;
    check("bp second accepted", 64'(busy), 64'd1);
    wait_result("bp second", 27, 5'd1, 6'd3);
    finish_result("bp second");

    // write during SCAN is dropped
    do_reset();
    write_cls(5'd0, 50'b10001);
    write_cls(5'd1, 50'b01110);
    start_query("lock", 50'b11111);
    repeat (3) @(posedge clk);
    #1;
    write_cls(5'd1, ALL1);
    wait_result("lock", 23, 5'd1, 6'd3);
    finish_result("lock");
    start_query("lock rb", ALL1);
    wait_result("lock rb", 27, 5'd1, 6'd3);
    finish_result("lock rb");

    // write coinciding with acceptance: scan sees old content, next query new
    do_reset();
    write_cls(5'd0, 50'b10001);
    write_cls(5'd1, 50'b01110);
    bus.q_valid = 1'b1; bus.query_hv = 50'b11111;
    cls_we = 1'b1; cls_waddr = 5'd1; cls_wdata = ALL1;
    @(posedge clk); #1;
    bus.q_valid = 1'b0; cls_we = 1'b0;
    wait_result("coinc", 27, 5'd1, 6'd3);
    finish_result("coinc");
    start_query("coinc rb", ALL1);
    wait_result("coinc rb", 27, 5'd1, 6'd50);
    finish_result("coinc rb");

    // reset mid-scan clears memory
    start_query("rst", ALL1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst q_ready", 64'(bus.q_ready), 64'd1);
    check("rst res_valid", 64'(bus.res_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    start_query("rst after", ALL1);
    wait_result("rst after", 27, 5'd0, 6'd0);
    finish_result("rst after");

`ifdef ASSOC_THRESH_EN
    do_reset();
    check("thr reset hit", 64'(bus.res_hit), 64'd0);
    write_cls(5'd0, 50'b10001);
    write_cls(5'd1, 50'b01110);
    bus.score_thresh = 6'd4;
    start_query("thr4", 50'b11111);
    wait_result("thr4", 27, 5'd1, 6'd3);
    check("thr4 hit", 64'(bus.res_hit), 64'd0);
    finish_result("thr4");
    bus.score_thresh = 6'd3;
    start_query("thr3", 50'b11111);
    wait_result("thr3", 27, 5'd1, 6'd3);
    check("thr3 hit", 64'(bus.res_hit), 64'd1);
    finish_result("thr3");
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
